// File: rtl/sprite_draw_datapath.sv
// Position registers and square-sprite pixel sweeper driven by the movement FSM.
// Decodes STATE/PorB, saturates movement at the screen edges and streams pixels to the VGA adapter.
module sprite_draw_datapath #(
  parameter int          SIZE     = 8,
  parameter int          STEP     = 1,
  parameter int          SCREEN_W = 160,
  parameter int          SCREEN_H = 120,
  parameter logic [7:0]  P_X0     = 8'd76,
  parameter logic [6:0]  P_Y0     = 7'd56,
  parameter logic [7:0]  B_X0     = 8'd0,
  parameter logic [6:0]  B_Y0     = 7'd100,
  parameter logic [2:0]  P_COL    = 3'b111,
  parameter logic [2:0]  B_COL    = 3'b110,
  parameter logic [2:0]  BG_COL   = 3'b011
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] STATE,
  input  logic       PorB,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       writeEn,
  output logic       doneDrawing,
  output logic [7:0] playerX,
  output logic [6:0] playerY,
  output logic [7:0] birdX,
  output logic [6:0] birdY
);

  localparam logic [3:0] ST_CLEAR = 4'b0001;
  localparam logic [3:0] ST_RIGHT = 4'b0010;
  localparam logic [3:0] ST_LEFT  = 4'b0011;
  localparam logic [3:0] ST_DRAW  = 4'b0101;
  localparam logic [3:0] ST_DOWN  = 4'b0110;
  localparam logic [3:0] ST_UP    = 4'b0111;

  localparam int NPIX = SIZE * SIZE;
  localparam int CW   = $clog2(NPIX + 1);
  localparam int XYW  = $clog2(SIZE + 1);

  localparam logic [CW-1:0]  NPIX_C = CW'(NPIX);
  localparam logic [XYW-1:0] C_LAST = XYW'(SIZE - 1);
  localparam logic [8:0]     X_MAX9 = 9'(SCREEN_W - SIZE);
  localparam logic [8:0]     Y_MAX9 = 9'(SCREEN_H - SIZE);
  localparam logic [8:0]     STEP9  = 9'(STEP);
  localparam logic [7:0]     STEP8  = 8'(STEP);
  localparam logic [6:0]     STEP7  = 7'(STEP);

  logic [3:0]     prev_state_r;
  logic [7:0]     player_x_r, bird_x_r, obj_x_r, x_r;
  logic [6:0]     player_y_r, bird_y_r, obj_y_r, y_r;
  logic [2:0]     colour_r, col_r;
  logic           we_r, done_r;
  logic [CW-1:0]  cnt_r;
  logic [XYW-1:0] cx_r, cy_r;

  logic [7:0]     player_x_n, bird_x_n, obj_x_n, x_n;
  logic [6:0]     player_y_n, bird_y_n, obj_y_n, y_n;
  logic [2:0]     colour_n, col_n;
  logic           we_n, done_n;
  logic [CW-1:0]  cnt_n;
  logic [XYW-1:0] cx_n, cy_n;

  logic           entry_s, sweep_s, emit_s;
  logic [7:0]     sel_x_s, right_x_s, left_x_s, base_x_s;
  logic [6:0]     sel_y_s, down_y_s, up_y_s, base_y_s;
  logic [8:0]     right9_s, down9_s;
  logic [XYW-1:0] cur_cx_s, cur_cy_s;
  logic [CW-1:0]  cur_cnt_s;
  logic [2:0]     pix_col_s;

  // Entry detection and saturating movement candidates for the selected object
  always_comb begin
    entry_s   = (STATE != prev_state_r);
    sel_x_s   = PorB ? bird_x_r : player_x_r;
    sel_y_s   = PorB ? bird_y_r : player_y_r;
    right9_s  = {1'b0, sel_x_s} + STEP9;
    right_x_s = (right9_s > X_MAX9) ? X_MAX9[7:0] : right9_s[7:0];
    left_x_s  = ({1'b0, sel_x_s} < STEP9) ? 8'd0 : (sel_x_s - STEP8);
    down9_s   = {2'b00, sel_y_s} + STEP9;
    down_y_s  = (down9_s > Y_MAX9) ? Y_MAX9[6:0] : down9_s[6:0];
    up_y_s    = ({2'b00, sel_y_s} < STEP9) ? 7'd0 : (sel_y_s - STEP7);
  end

  // Position update, applied once on the first cycle of a movement state
  always_comb begin
    player_x_n = player_x_r;
    player_y_n = player_y_r;
    bird_x_n   = bird_x_r;
    bird_y_n   = bird_y_r;
    if (entry_s) begin
      case (STATE)
        ST_RIGHT: if (PorB) bird_x_n = right_x_s; else player_x_n = right_x_s;
        ST_LEFT:  if (PorB) bird_x_n = left_x_s;  else player_x_n = left_x_s;
        ST_DOWN:  if (PorB) bird_y_n = down_y_s;  else player_y_n = down_y_s;
        ST_UP:    if (PorB) bird_y_n = up_y_s;    else player_y_n = up_y_s;
        default:  player_x_n = player_x_r;
      endcase
    end else begin
      player_x_n = player_x_r;
    end
  end

  // Sweep engine: the entry edge registers pixel (0,0), so writes appear on cycles 1..SIZE*SIZE
  always_comb begin
    sweep_s   = (STATE == ST_CLEAR) || (STATE == ST_DRAW);
    emit_s    = sweep_s && (entry_s || (cnt_r < NPIX_C));
    base_x_s  = entry_s ? sel_x_s : obj_x_r;
    base_y_s  = entry_s ? sel_y_s : obj_y_r;
    cur_cx_s  = entry_s ? {XYW{1'b0}} : cx_r;
    cur_cy_s  = entry_s ? {XYW{1'b0}} : cy_r;
    cur_cnt_s = entry_s ? {CW{1'b0}} : cnt_r;
    if (!entry_s) begin
      pix_col_s = col_r;
    end else if (STATE == ST_CLEAR) begin
      pix_col_s = BG_COL;
    end else begin
      pix_col_s = PorB ? B_COL : P_COL;
    end

    x_n      = x_r;
    y_n      = y_r;
    colour_n = colour_r;
    we_n     = 1'b0;
    done_n   = 1'b0;
    cnt_n    = cnt_r;
    cx_n     = cx_r;
    cy_n     = cy_r;
    obj_x_n  = obj_x_r;
    obj_y_n  = obj_y_r;
    col_n    = col_r;
    if (emit_s) begin
      obj_x_n  = base_x_s;
      obj_y_n  = base_y_s;
      col_n    = pix_col_s;
      x_n      = base_x_s + {{(8 - XYW){1'b0}}, cur_cx_s};
      y_n      = base_y_s + {{(7 - XYW){1'b0}}, cur_cy_s};
      colour_n = pix_col_s;
      we_n     = 1'b1;
      cnt_n    = cur_cnt_s + {{(CW - 1){1'b0}}, 1'b1};
      if (cur_cx_s == C_LAST) begin
        cx_n = {XYW{1'b0}};
        cy_n = cur_cy_s + {{(XYW - 1){1'b0}}, 1'b1};
      end else begin
        cx_n = cur_cx_s + {{(XYW - 1){1'b0}}, 1'b1};
        cy_n = cur_cy_s;
      end
    end else if (sweep_s) begin
      done_n = 1'b1;
    end else begin
      cnt_n = {CW{1'b0}};
      cx_n  = {XYW{1'b0}};
      cy_n  = {XYW{1'b0}};
    end
  end

  // State register for positions, sweep progress and the registered pixel port
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_state_r <= 4'b1111;
      player_x_r   <= P_X0;
      player_y_r   <= P_Y0;
      bird_x_r     <= B_X0;
      bird_y_r     <= B_Y0;
      obj_x_r      <= 8'd0;
      obj_y_r      <= 7'd0;
      col_r        <= 3'd0;
      x_r          <= 8'd0;
      y_r          <= 7'd0;
      colour_r     <= 3'd0;
      we_r         <= 1'b0;
      done_r       <= 1'b0;
      cnt_r        <= {CW{1'b0}};
      cx_r         <= {XYW{1'b0}};
      cy_r         <= {XYW{1'b0}};
    end else begin
      prev_state_r <= STATE;
      player_x_r   <= player_x_n;
      player_y_r   <= player_y_n;
      bird_x_r     <= bird_x_n;
      bird_y_r     <= bird_y_n;
      obj_x_r      <= obj_x_n;
      obj_y_r      <= obj_y_n;
      col_r        <= col_n;
      x_r          <= x_n;
      y_r          <= y_n;
      colour_r     <= colour_n;
      we_r         <= we_n;
      done_r       <= done_n;
      cnt_r        <= cnt_n;
      cx_r         <= cx_n;
      cy_r         <= cy_n;
    end
  end

  // Done is masked on the entry cycle so a back-to-back sweep never sees a stale done
  assign doneDrawing = done_r & ~entry_s;
  assign x       = x_r;
  assign y       = y_r;
  assign colour  = colour_r;
  assign writeEn = we_r;
  assign playerX = player_x_r;
  assign playerY = player_y_r;
  assign birdX   = bird_x_r;
  assign birdY   = bird_y_r;

endmodule

// File: tb/tb_sprite_draw_datapath.sv
// Directed self-checking bench for sprite_draw_datapath: sweeps, saturating moves, abort and reset.
module tb_sprite_draw_datapath;

  localparam logic [3:0] IDLE  = 4'b0000;
  localparam logic [3:0] CLEAR = 4'b0001;
  localparam logic [3:0] RIGHT = 4'b0010;
  localparam logic [3:0] LEFT  = 4'b0011;
  localparam logic [3:0] OTHER = 4'b0100;
  localparam logic [3:0] DRAW  = 4'b0101;
  localparam logic [3:0] DOWN  = 4'b0110;
  localparam logic [3:0] UP    = 4'b0111;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] STATE;
  logic       PorB;
  logic [7:0] x, playerX, birdX;
  logic [6:0] y, playerY, birdY;
  logic [2:0] colour;
  logic       writeEn, doneDrawing;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0] st;
    logic       pb;
    int         reps;
    int         hold;
    int         px, py, bx, by;
  } mv_t;

  mv_t mv [12];

  sprite_draw_datapath dut (
    .clk(clk), .reset_n(reset_n), .STATE(STATE), .PorB(PorB),
    .x(x), .y(y), .colour(colour), .writeEn(writeEn), .doneDrawing(doneDrawing),
    .playerX(playerX), .playerY(playerY), .birdX(birdX), .birdY(birdY)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One cycle: drive inputs just after the rising edge, sample at the falling edge
  task automatic cyc(input logic [3:0] st, input logic pb);
    @(posedge clk);
    #1;
    STATE = st;
    PorB  = pb;
    @(negedge clk);
  endtask

  task automatic sweep(input string name, input bit do_entry, input logic [3:0] st,
                       input logic pb, input logic pb_after, input int ex, input int ey,
                       input logic [2:0] ecol);
    logic [18:0] e;
    logic [18:0] a;
    if (do_entry) cyc(st, pb);
    else @(negedge clk);
    chk({name, ".entry_we"}, 32'(writeEn), 32'd0);
    chk({name, ".entry_done"}, 32'(doneDrawing), 32'd0);
    for (int i = 0; i < 64; i++) begin
      cyc(st, pb_after);
      e = {1'b1, 8'(ex + i % 8), 7'(ey + i / 8), ecol};
      a = {writeEn, x, y, colour};
      chk($sformatf("%s.pix%0d", name, i), 32'(a), 32'(e));
      chk($sformatf("%s.busy%0d", name, i), 32'(doneDrawing), 32'd0);
    end
    cyc(st, pb_after);
    chk({name, ".end_we"}, 32'(writeEn), 32'd0);
    chk({name, ".done65"}, 32'(doneDrawing), 32'd1);
    cyc(st, pb_after);
    chk({name, ".done66"}, 32'(doneDrawing), 32'd1);
  endtask

  task automatic chk_pos(input string name, input int px, input int py, input int bx, input int by);
    chk({name, ".playerX"}, 32'(playerX), 32'(px));
    chk({name, ".playerY"}, 32'(playerY), 32'(py));
    chk({name, ".birdX"}, 32'(birdX), 32'(bx));
    chk({name, ".birdY"}, 32'(birdY), 32'(by));
  endtask

  initial begin
    mv[0]  = '{RIGHT, 1'b0, 76,  1, 152, 56,  0, 100};
    mv[1]  = '{RIGHT, 1'b0, 3,   1, 152, 56,  0, 100};
    mv[2]  = '{LEFT,  1'b0, 3,   1, 149, 56,  0, 100};
    mv[3]  = '{UP,    1'b1, 100, 1, 149, 56,  0, 0};
    mv[4]  = '{UP,    1'b1, 1,   1, 149, 56,  0, 0};
    mv[5]  = '{DOWN,  1'b1, 1,   1, 149, 56,  0, 1};
    mv[6]  = '{LEFT,  1'b1, 2,   1, 149, 56,  0, 1};
    mv[7]  = '{DOWN,  1'b0, 70,  1, 149, 112, 0, 1};
    mv[8]  = '{UP,    1'b0, 1,   1, 149, 111, 0, 1};
    mv[9]  = '{RIGHT, 1'b1, 5,   1, 149, 111, 5, 1};
    mv[10] = '{LEFT,  1'b0, 1,   5, 148, 111, 5, 1};
    mv[11] = '{OTHER, 1'b0, 3,   2, 148, 111, 5, 1};

    reset_n = 1'b0;
    STATE   = CLEAR;
    PorB    = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.pixel", 32'({writeEn, x, y, colour}), 32'd0);
    chk("rst.done", 32'(doneDrawing), 32'd0);
    chk_pos("rst", 76, 56, 0, 100);

    // Player erase straight out of reset
    @(posedge clk);
    #1 reset_n = 1'b1;
    sweep("clr_rst", 1'b0, CLEAR, 1'b0, 1'b0, 76, 56, 3'b011);

    // Bird draw out of reset; PorB flips mid-sweep and must be ignored
    reset_n = 1'b0;
    STATE   = DRAW;
    PorB    = 1'b1;
    @(posedge clk);
    #1 reset_n = 1'b1;
    sweep("draw_bird", 1'b0, DRAW, 1'b1, 1'b0, 0, 100, 3'b110);

    for (int k = 0; k < 12; k++) begin
      for (int r = 0; r < mv[k].reps; r++) begin
        for (int h = 0; h < mv[k].hold; h++) cyc(mv[k].st, mv[k].pb);
        cyc(IDLE, mv[k].pb);
      end
      chk_pos($sformatf("mv%0d", k), mv[k].px, mv[k].py, mv[k].bx, mv[k].by);
      chk($sformatf("mv%0d.we", k), 32'(writeEn), 32'd0);
    end

    // Completed DRAW followed directly by CLEAR
    sweep("draw_p", 1'b1, DRAW, 1'b0, 1'b0, 148, 111, 3'b111);
    sweep("clr_direct", 1'b1, CLEAR, 1'b0, 1'b0, 148, 111, 3'b011);

    // Abort a DRAW after 20 pixels, then restart from offset (0,0)
    cyc(DRAW, 1'b0);
    for (int i = 0; i < 20; i++) cyc(DRAW, 1'b0);
    chk("abort.we_before", 32'(writeEn), 32'd1);
    cyc(IDLE, 1'b0);
    cyc(IDLE, 1'b0);
    chk("abort.we_after", 32'(writeEn), 32'd0);
    chk("abort.done", 32'(doneDrawing), 32'd0);
    sweep("draw_restart", 1'b1, DRAW, 1'b0, 1'b0, 148, 111, 3'b111);

    // Reset while done is high drops done and restores positions immediately
    #2 reset_n = 1'b0;
    #1;
    chk("rst_done.done", 32'(doneDrawing), 32'd0);
    chk("rst_done.pixel", 32'({writeEn, x, y, colour}), 32'd0);
    chk_pos("rst_done", 76, 56, 0, 100);

    // Reset in the middle of an active sweep
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 10; i++) cyc(DRAW, 1'b0);
    chk("mid.we_active", 32'({writeEn, x, y}), 32'({1'b1, 8'd77, 7'd57}));
    #2 reset_n = 1'b0;
    #1;
    chk("mid.we", 32'(writeEn), 32'd0);
    chk("mid.done", 32'(doneDrawing), 32'd0);
    chk("mid.xy", 32'({x, y}), 32'd0);
    chk_pos("mid", 76, 56, 0, 100);
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sprite_draw_datapath.md
Name: sprite_draw_datapath

Overview:
- Datapath and pixel engine directly downstream of the movement FSM. It decodes the FSM's 4-bit STATE and PorB object select.
- It updates the player-crosshair and bird positions, and sweeps square sprites into the VGA adapter's pixel port.
- It returns doneDrawing to the FSM.
- It exports both object positions to the hit-detection logic.

Parameters:
- SIZE, 8, sprite edge in pixels (square).
- STEP, 1, pixels moved per movement state.
- SCREEN_W, 160, screen width in pixels.
- SCREEN_H, 120, screen height in pixels.
- P_X0, 76, player reset X.
- P_Y0, 56, player reset Y.
- B_X0, 0, bird reset X.
- B_Y0, 100, bird reset Y.
- P_COL, 3'b111, player colour.
- B_COL, 3'b110, bird colour.
- BG_COL, 3'b011, background (erase) colour.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- STATE  in  4  FSM state code
- PorB  in  1  object select: 0 = player, 1 = bird
- x  out  8  pixel X to the VGA adapter
- y  out  7  pixel Y to the VGA adapter
- colour  out  3  pixel colour
- writeEn  out  1  pixel write strobe
- doneDrawing  out  1  current sweep complete
- playerX  out  8  player top-left X
- playerY  out  7  player top-left Y
- birdX  out  8  bird top-left X
- birdY  out  7  bird top-left Y

Behaviour:
- Single clock domain on clk; reset is asynchronous active-low on reset_n.
- Reset values:
  - playerX/Y = P_X0/P_Y0; birdX/Y = B_X0/B_Y0.
  - x = 0, y = 0, colour = 0, writeEn = 0, done register = 0.
  - Pixel counter = 0; prev_state = 4'b1111, so the first post-reset cycle counts as a state entry.
- State codes decoded: CLEAR 0001, RIGHT 0010, LEFT 0011, DOWN 0110, UP 0111, DRAW 0101. All other codes are idle: writeEn = 0, positions held.
- Entry detection: prev_state <= STATE every cycle; entry = (STATE != prev_state).
- Movement: RIGHT/LEFT/DOWN/UP each apply exactly once, on the first cycle of that state, to the object selected by PorB in that cycle.
  - RIGHT: X = min(X+STEP, SCREEN_W-SIZE).
  - LEFT: X = max(X-STEP, 0); no wrap below 0.
  - DOWN: Y = min(Y+STEP, SCREEN_H-SIZE).
  - UP: Y = max(Y-STEP, 0).
  - Saturation is computed at 9-bit width to avoid overflow.
  - Each movement state lasts one cycle in the FSM. If it lasts longer, it still moves only once per entry.
- Sweep (CLEAR or DRAW):
  - On the entry cycle (cycle 0): counter cleared, done register cleared, writeEn = 0.
  - Cycles 1..SIZE*SIZE: writeEn = 1, x = objX + cx, y = objY + cy.
    - Row-major order: cx increments fastest, 0..SIZE-1, then cy increments.
    - colour = BG_COL in CLEAR; P_COL or B_COL (per PorB) in DRAW.
    - Object position is sampled at entry and held for the whole sweep.
  - Cycle SIZE*SIZE+1 onward: writeEn = 0, done register = 1 until STATE changes.
- doneDrawing = done register AND NOT entry (combinational).
  - Guarantees doneDrawing = 0 on the first cycle of any new CLEAR/DRAW, including a direct DRAW->CLEAR transition.
  - Always 0 in non-sweep states.
- Sweep interrupted by a STATE change: writeEn drops the next cycle and the counter resets. Partial sweeps are not resumed.
- PorB change mid-sweep is ignored; object and colour are latched at entry.
- Reset mid-sweep: all outputs return to reset values immediately (asynchronous). The next sweep starts from cycle 0.
- Pixels never leave the screen because positions are saturated to SCREEN-SIZE.

Test Plan:
- Release reset with STATE=0001, PorB=0:
  - writeEn high for 64 cycles.
  - x spans 76..83, y spans 56..63, colour = 3'b011.
  - doneDrawing rises on cycle 65 and stays high.
- Hold STATE=0101, PorB=1 after reset:
  - 64 writes at birdX 0..7, birdY 100..107, colour 3'b110.
  - doneDrawing = 0 on entry cycle; high on cycle 65.
- Player at X=152: pulse RIGHT (0010) three times with PorB=0:
  - playerX stays 152.
  - Then LEFT three times -> playerX = 149.
- Bird at Y=0: UP (0111) pulse -> birdY stays 0. DOWN pulse -> birdY = 1. playerY unchanged throughout.
- Complete a DRAW sweep (doneDrawing=1), then switch directly to CLEAR:
  - doneDrawing = 0 on the first CLEAR cycle.
  - New 64-pixel erase sweep; doneDrawing high 65 cycles after entry.
- Abort and reset:
  - Switch to 0000 at pixel 20 of a DRAW sweep -> writeEn = 0 next cycle; re-entering DRAW restarts at offset (0,0).
  - Assert reset_n=0 mid-sweep -> writeEn and doneDrawing drop immediately; positions return to P_X0/P_Y0 and B_X0/B_Y0.
